// File: rtl/telem_pkg.sv
// Shared telemetry link constants and state types, used by both ends of the link.
package telem_pkg;

  localparam logic [7:0] SYNC1     = 8'hAA;
  localparam logic [7:0] SYNC2     = 8'h55;
  localparam int         PKT_LEN   = 8;
  localparam int         DATA_LEN  = PKT_LEN - 2;
  localparam int         UART_BITS = 10;

  typedef enum logic [1:0] {
    SYNC_AA,
    SYNC_55,
    DATA
  } telem_rx_st_t;

  typedef enum logic {
    UART_IDLE,
    UART_RECV
  } uart_st_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchroniser, mid-bit baud sampler and shift register.
// With TELEM_RX_TIMEOUT_EN defined an extra rx_busy output reports an active frame.
module uart_rx_byte
  import telem_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       byte_rdy,
  output logic       frm_err
`ifdef TELEM_RX_TIMEOUT_EN
  ,
  output logic       rx_busy
`endif
);

  localparam int CW = $clog2(BAUD_DIV);

  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  uart_st_t      st_reg, st_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    bit_reg, bit_next;
  logic [7:0]    sh_reg, sh_next;
  logic [7:0]    data_reg, data_next;
  logic          rdy_reg, rdy_next;
  logic          ferr_reg, ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      st_reg      <= UART_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      sh_reg      <= '0;
      data_reg    <= '0;
      rdy_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      st_reg      <= st_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      sh_reg      <= sh_next;
      data_reg    <= data_next;
      rdy_reg     <= rdy_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    st_next   = st_reg;
    cnt_next  = cnt_reg;
    bit_next  = bit_reg;
    sh_next   = sh_reg;
    data_next = data_reg;
    rdy_next  = 1'b0;
    ferr_next = 1'b0;
    case (st_reg)
      UART_IDLE: begin
        // First sample lands half a bit after the falling edge: mid start bit.
        if (rx_prev_reg && !rx_sync_reg) begin
          st_next  = UART_RECV;
          cnt_next = CW'(BAUD_DIV / 2 - 1);
          bit_next = '0;
        end
      end
      UART_RECV: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          cnt_next = CW'(BAUD_DIV - 1);
          bit_next = bit_reg + 4'd1;
          if (bit_reg == 4'd0) begin
            if (rx_sync_reg) st_next = UART_IDLE;
          end else if (bit_reg == 4'(UART_BITS - 1)) begin
            st_next = UART_IDLE;
            if (rx_sync_reg) begin
              rdy_next  = 1'b1;
              data_next = sh_reg;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            sh_next = {rx_sync_reg, sh_reg[7:1]};
          end
        end
      end
      default: st_next = UART_IDLE;
    endcase
  end

  assign rx_data  = data_reg;
  assign byte_rdy = rdy_reg;
  assign frm_err  = ferr_reg;
`ifdef TELEM_RX_TIMEOUT_EN
  assign rx_busy  = (st_reg == UART_RECV);
`endif

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: re-frames AA 55 + 6 data bytes into three 12-bit words.
// Define TELEM_RX_TIMEOUT_EN to abandon a stalled packet after TO_BITS idle bit periods.
module telemetry_rx
  import telem_pkg::*;
#(
  parameter int BAUD_DIV = 2604
`ifdef TELEM_RX_TIMEOUT_EN
  ,
  parameter int TO_BITS  = 24
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        vld,
  output logic        pkt_err
);

  logic [7:0]   rx_byte;
  logic         byte_rdy, frm_err;
  telem_rx_st_t st_reg, st_next;
  logic [2:0]   idx_reg, idx_next;
  logic [11:0]  sh_reg [3];
  logic [11:0]  sh_next [3];
  logic [11:0]  word_reg [3];
  logic [11:0]  word_next [3];
  logic         vld_reg, vld_next;
  logic         err_reg, err_next;

`ifdef TELEM_RX_TIMEOUT_EN
  localparam int TO_CLKS = TO_BITS * BAUD_DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  logic          rx_busy;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
`endif

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_byte),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err)
`ifdef TELEM_RX_TIMEOUT_EN
    ,
    .rx_busy  (rx_busy)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg  <= SYNC_AA;
      idx_reg <= '0;
      vld_reg <= 1'b0;
      err_reg <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        sh_reg[k]   <= '0;
        word_reg[k] <= '0;
      end
`ifdef TELEM_RX_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
    end else begin
      st_reg  <= st_next;
      idx_reg <= idx_next;
      vld_reg <= vld_next;
      err_reg <= err_next;
      for (int k = 0; k < 3; k++) begin
        sh_reg[k]   <= sh_next[k];
        word_reg[k] <= word_next[k];
      end
`ifdef TELEM_RX_TIMEOUT_EN
      to_cnt_reg <= to_cnt_next;
`endif
    end
  end

  always_comb begin
    st_next   = st_reg;
    idx_next  = idx_reg;
    sh_next   = sh_reg;
    word_next = word_reg;
    vld_next  = 1'b0;
    err_next  = frm_err;
    if (frm_err) begin
      st_next = SYNC_AA;
    end else if (byte_rdy) begin
      case (st_reg)
        SYNC_AA: if (rx_byte == SYNC1) st_next = SYNC_55;
        SYNC_55: begin
          if (rx_byte == SYNC2) begin
            st_next  = DATA;
            idx_next = '0;
          end else if (rx_byte != SYNC1) begin
            st_next = SYNC_AA;
          end
        end
        DATA: begin
          idx_next = idx_reg + 3'd1;
          // Even index = hi byte of a 12-bit word; any upper-nibble bit is a format error.
          if (!idx_reg[0]) begin
            if (rx_byte[7:4] != 4'h0) begin
              err_next = 1'b1;
              st_next  = SYNC_AA;
            end else begin
              sh_next[idx_reg[2:1]][11:8] = rx_byte[3:0];
            end
          end else begin
            sh_next[idx_reg[2:1]][7:0] = rx_byte;
            if (idx_reg == 3'(DATA_LEN - 1)) begin
              word_next = sh_next;
              vld_next  = 1'b1;
              st_next   = SYNC_AA;
            end
          end
        end
        default: st_next = SYNC_AA;
      endcase
    end
`ifdef TELEM_RX_TIMEOUT_EN
    to_cnt_next = to_cnt_reg;
    if (byte_rdy || st_reg == SYNC_AA) begin
      to_cnt_next = '0;
    end else if (!rx_busy) begin
      if (to_cnt_reg == TW'(TO_CLKS - 1)) begin
        to_cnt_next = '0;
        st_next     = SYNC_AA;
        err_next    = 1'b1;
      end else begin
        to_cnt_next = to_cnt_reg + TW'(1);
      end
    end
`endif
  end

  assign batt_v     = word_reg[0];
  assign avg_curr   = word_reg[1];
  assign avg_torque = word_reg[2];
  assign vld        = vld_reg;
  assign pkt_err    = err_reg;

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: serial byte model, table of packets and a scoreboard of vld/pkt_err events.
module tb_telemetry_rx;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        vld, pkt_err;

  telemetry_rx #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .batt_v     (batt_v),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .vld        (vld),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [11:0][7:0] b;        // b[11] is sent first
    int               bad_stop; // byte index sent with stop bit 0, -1 for none
    int               kind;     // 0 nothing, 1 vld, 2 pkt_err
    logic [11:0]      eb, ec, et;
    int               gap;      // idle bit periods after each byte
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [11:0] b, c, t;
  } exp_t;

  vec_t        vecs [7];
  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] hold_b = '0, hold_c = '0, hold_t = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    RX = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * BD) @(negedge clk);
  endtask

  task automatic expect_evt(input bit is_err, input logic [11:0] b, input logic [11:0] c,
                            input logic [11:0] t);
    exp_t e;
    e.is_err = is_err;
    e.b = b;
    e.c = c;
    e.t = t;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld || pkt_err) begin
        chk("vld_err_exclusive", 32'(vld & pkt_err), 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_event", {30'd0, vld, pkt_err}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("event_kind", {30'd0, vld, pkt_err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) begin
            chk("batt_v", 32'(batt_v), 32'(e.b));
            chk("avg_curr", 32'(avg_curr), 32'(e.c));
            chk("avg_torque", 32'(avg_torque), 32'(e.t));
            hold_b = e.b;
            hold_c = e.c;
            hold_t = e.t;
          end
          $display("event %s batt=%h curr=%h torq=%h @%0t", e.is_err ? "pkt_err" : "vld",
                   batt_v, avg_curr, avg_torque, $time);
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    repeat (4 * BD) @(negedge clk);
    chk("pending_events", 32'(q.size()), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_hold_batt"}, 32'(batt_v), 32'(hold_b));
    chk({tag, "_hold_curr"}, 32'(avg_curr), 32'(hold_c));
    chk({tag, "_hold_torq"}, 32'(avg_torque), 32'(hold_t));
  endtask

  task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte({4'h0, b[11:8]}, 1'b1);
    send_byte(b[7:0], 1'b1);
    send_byte({4'h0, c[11:8]}, 1'b1);
    send_byte(c[7:0], 1'b1);
    send_byte({4'h0, t[11:8]}, 1'b1);
    send_byte(t[7:0], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8, {8'hAA, 8'h55, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h07, 8'hFF, 32'h0},
                -1, 1, 12'hA98, 12'h123, 12'h7FF, 0};
    vecs[1] = '{10, {8'h13, 8'hAA, 8'hAA, 8'h55, 8'h04, 8'h56, 8'h00, 8'h00, 8'h0F, 8'hFF, 16'h0},
                -1, 1, 12'h456, 12'h000, 12'hFFF, 1};
    vecs[2] = '{8, {8'hAA, 8'h55, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h07, 8'hFF, 32'h0},
                4, 2, 12'h0, 12'h0, 12'h0, 1};
    vecs[3] = '{8, {8'hAA, 8'h55, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 32'h0},
                -1, 1, 12'h111, 12'h222, 12'h333, 2};
    vecs[4] = '{8, {8'hAA, 8'h55, 8'h0A, 8'h98, 8'h31, 8'h23, 8'h07, 8'hFF, 32'h0},
                -1, 2, 12'h0, 12'h0, 12'h0, 1};
    vecs[5] = '{10, {8'hAA, 8'h12, 8'hAA, 8'h55, 8'h0F, 8'h00, 8'h08, 8'h00, 8'h00, 8'h01, 16'h0},
                -1, 1, 12'hF00, 12'h800, 12'h001, 0};
    vecs[6] = '{8, {8'hAA, 8'h55, 8'h00, 8'hAA, 8'h05, 8'h55, 8'h0B, 8'hAA, 32'h0},
                -1, 1, 12'h0AA, 12'h555, 12'hBAA, 1};

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_batt", 32'(batt_v), 32'd0);
    chk("rst_curr", 32'(avg_curr), 32'd0);
    chk("rst_torq", 32'(avg_torque), 32'd0);
    chk("rst_flags", {30'd0, vld, pkt_err}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Table of packets
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].kind != 0)
        expect_evt(vecs[i].kind == 2, vecs[i].eb, vecs[i].ec, vecs[i].et);
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte(vecs[i].b[11 - j], (j == vecs[i].bad_stop) ? 1'b0 : 1'b1);
        idle_bits(vecs[i].gap);
      end
      drain();
      check_hold($sformatf("vec%0d", i));
      $display("txn vec%0d bytes=%0d kind=%0d batt=%h curr=%h torq=%h", i, vecs[i].n,
               vecs[i].kind, batt_v, avg_curr, avg_torque);
    end

    // Three packets with zero idle gap, then a short low glitch on idle RX
    expect_evt(1'b0, 12'h321, 12'h654, 12'h987);
    expect_evt(1'b0, 12'h0F0, 12'h00F, 12'hF00);
    expect_evt(1'b0, 12'hABC, 12'hDEF, 12'h012);
    send_pkt(12'h321, 12'h654, 12'h987);
    send_pkt(12'h0F0, 12'h00F, 12'hF00);
    send_pkt(12'hABC, 12'hDEF, 12'h012);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    drain();
    check_hold("b2b");
    $display("txn back_to_back batt=%h curr=%h torq=%h", batt_v, avg_curr, avg_torque);

    // Stalled packet: AA 55 0A then 25 idle bit times
`ifdef TELEM_RX_TIMEOUT_EN
    expect_evt(1'b1, 12'h0, 12'h0, 12'h0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    idle_bits(25);
    drain();
    check_hold("timeout");
    expect_evt(1'b0, 12'hA98, 12'h123, 12'h7FF);
    send_pkt(12'hA98, 12'h123, 12'h7FF);
`else
    expect_evt(1'b0, 12'hA98, 12'h123, 12'h7FF);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    idle_bits(25);
    send_byte(8'h98, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'hFF, 1'b1);
`endif
    drain();
    check_hold("stall");
    $display("txn stall batt=%h curr=%h torq=%h", batt_v, avg_curr, avg_torque);

    // Asynchronous reset mid-packet, then resume mid-stream
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_batt", 32'(batt_v), 32'd0);
    chk("midrst_curr", 32'(avg_curr), 32'd0);
    chk("midrst_torq", 32'(avg_torque), 32'd0);
    hold_b = '0;
    hold_c = '0;
    hold_t = '0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(1);
    send_byte(8'h98, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'hFF, 1'b1);
    drain();
    check_hold("resume");
    expect_evt(1'b0, 12'h246, 12'h8AC, 12'hE02);
    send_pkt(12'h246, 12'h8AC, 12'hE02);
    drain();
    check_hold("recover");
    $display("txn reset_resume batt=%h curr=%h torq=%h", batt_v, avg_curr, avg_torque);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
